// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// The optional MULDIV_FLUSH_EN build adds a flush input to muldiv_if.
package muldiv_pkg;

    localparam int DATA_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    function automatic logic op_is_signed(input op_e op);
        return op[0];
    endfunction

    function automatic logic op_is_div(input op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the execute-stage control and muldiv_unit.
// MULDIV_FLUSH_EN adds the flush request.
interface muldiv_if #(parameter int DATA_WIDTH = muldiv_pkg::DATA_WIDTH_DEF);
    logic                  start;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] operand1;
    logic [DATA_WIDTH-1:0] operand2;
    logic                  hi_we;
    logic                  lo_we;
    logic [DATA_WIDTH-1:0] hilo_wdata;
`ifdef MULDIV_FLUSH_EN
    logic                  flush;
`endif
    logic                  busy;
    logic                  done;
    logic                  div_by_zero;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;

    modport master (
`ifdef MULDIV_FLUSH_EN
        output flush,
`endif
        output start, op, operand1, operand2, hi_we, lo_we, hilo_wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
`ifdef MULDIV_FLUSH_EN
        input  flush,
`endif
        input  start, op, operand1, operand2, hi_we, lo_we, hilo_wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_abs_neg.sv
// Conditional two's-complement negate: absolute value of operands on entry,
// sign restoration of results on exit.
module muldiv_abs_neg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_val
);
    assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one step per cycle, fixed latency.
// Optional MULDIV_FLUSH_EN: flush aborts CALC/FIX back to IDLE without touching HI/LO.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = 6
) (
    input  logic      clk,
    input  logic      rst_n,
    muldiv_if.slave   io_bus
);
    localparam int W = DATA_WIDTH;

    state_e               r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    op_e                  r_op;
    logic [2*W-1:0]       r_prod;
    logic [W-1:0]         r_dvsr, r_hi, r_lo;
    logic                 r_neg_res, r_neg_rem, r_div0, r_dbz;

    logic                 w_busy, w_start_ok, w_flush, w_last, w_fix_wr;
    op_e                  w_op_in;
    logic                 w_sign1, w_sign2;
    logic [W-1:0]         w_abs1, w_abs2, w_rem;
    logic [W:0]           w_madd, w_shift, w_diff;
    logic                 w_ge;
    logic [2*W-1:0]       w_step, w_res_in, w_res;

`ifdef MULDIV_FLUSH_EN
    assign w_flush = io_bus.flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_busy     = (r_state == S_CALC) || (r_state == S_FIX);
    assign w_start_ok = io_bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last     = (r_cnt == CNT_WIDTH'(W - 1));
    assign w_fix_wr   = (r_state == S_FIX) && !w_flush;

    assign w_op_in = op_e'(io_bus.op);
    assign w_sign1 = op_is_signed(w_op_in) && io_bus.operand1[W-1];
    assign w_sign2 = op_is_signed(w_op_in) && io_bus.operand2[W-1];

    muldiv_abs_neg #(.WIDTH(W)) u_abs1 (.i_val(io_bus.operand1), .i_neg(w_sign1), .o_val(w_abs1));
    muldiv_abs_neg #(.WIDTH(W)) u_abs2 (.i_val(io_bus.operand2), .i_neg(w_sign2), .o_val(w_abs2));

    // r_prod is {partial product, multiplier} for multiply and {remainder, quotient} for divide
    assign w_madd  = {1'b0, r_prod[2*W-1:W]} + (r_prod[0] ? {1'b0, r_dvsr} : '0);
    assign w_shift = r_prod[2*W-1:W-1];
    assign w_diff  = w_shift - {1'b0, r_dvsr};
    assign w_ge    = !w_diff[W];
    assign w_step  = op_is_div(r_op)
                   ? {(w_ge ? w_diff[W-1:0] : w_shift[W-1:0]), r_prod[W-2:0], w_ge}
                   : {w_madd, r_prod[W-1:1]};

    assign w_res_in = op_is_div(r_op) ? {{W{1'b0}}, r_prod[W-1:0]} : r_prod;
    muldiv_abs_neg #(.WIDTH(2*W)) u_res (.i_val(w_res_in), .i_neg(r_neg_res), .o_val(w_res));
    muldiv_abs_neg #(.WIDTH(W)) u_rem (.i_val(r_prod[2*W-1:W]), .i_neg(r_neg_rem), .o_val(w_rem));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: w_state_nxt = io_bus.start ? S_CALC : S_IDLE;
            S_CALC:         if (w_last) w_state_nxt = S_FIX;
            S_FIX:          w_state_nxt = S_DONE;
            default:        w_state_nxt = S_IDLE;
        endcase
        if (w_flush && w_busy) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_op      <= OP_MULTU;
            r_prod    <= '0;
            r_dvsr    <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_div0    <= 1'b0;
            r_dbz     <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            if (w_start_ok) begin
                r_op      <= w_op_in;
                r_cnt     <= '0;
                r_dbz     <= 1'b0;
                r_div0    <= op_is_div(w_op_in) && (io_bus.operand2 == '0);
                r_neg_res <= w_sign1 ^ w_sign2;
                r_neg_rem <= w_sign1;
                r_prod    <= {{W{1'b0}}, op_is_div(w_op_in) ? w_abs1 : w_abs2};
                r_dvsr    <= op_is_div(w_op_in) ? w_abs2 : w_abs1;
            end else if (r_state == S_CALC) begin
                r_prod <= w_step;
                r_cnt  <= r_cnt + CNT_WIDTH'(1);
            end

            if (w_flush && w_busy) r_dbz <= 1'b0;

            // Divide by zero: remainder path already holds the original dividend
            if (w_fix_wr) begin
                r_dbz <= r_div0;
                if (op_is_div(r_op)) begin
                    r_lo <= r_div0 ? '1 : w_res[W-1:0];
                    r_hi <= w_rem;
                end else begin
                    r_lo <= w_res[W-1:0];
                    r_hi <= w_res[2*W-1:W];
                end
            end else if (!w_busy) begin
                if (io_bus.hi_we) r_hi <= io_bus.hilo_wdata;
                if (io_bus.lo_we) r_lo <= io_bus.hilo_wdata;
            end
        end
    end

    assign io_bus.busy        = w_busy;
    assign io_bus.done        = (r_state == S_DONE);
    assign io_bus.div_by_zero = r_dbz;
    assign io_bus.hi          = r_hi;
    assign io_bus.lo          = r_lo;

endmodule
